// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared encodings, widths and mode lookup for the frame link sequencer
package frame_pkg;

    localparam int         FRAME_LEN_DEFAULT = 256;
    localparam logic [7:0] SYNC_WORD         = 8'b10011011;
    localparam int         MODE_W            = 2;
    localparam int         NUM_MODES         = 4;
    localparam int         ERR_W             = 16;
    localparam int         FRAME_W           = 16;
    localparam int         LOSS_W            = 8;

    typedef enum logic [1:0] {
        SYNC_SEARCH   = 2'b00,
        SYNC_VERIFY   = 2'b01,
        SYNC_LOCKED   = 2'b10,
        SYNC_HOLDOVER = 2'b11
    } sync_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LOCK,
        ST_MEASURE,
        ST_DONE
    } ctrl_state_e;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } mode_e;

    // Lowest enabled mode at or above 'from'; bit 2 says whether one exists.
    function automatic logic [2:0] find_mode(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int k = NUM_MODES - 1; k >= 0; k--) begin
            if (mask[k] && (3'(k) >= from)) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable down-counter with terminal-count pulse for the lock timeout
module frame_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    // Loaded with N-1, so the pulse lands on the Nth enabled cycle after the load.
    assign expired = enable && !load && (count_q == '0);

endmodule

// File: rtl/frame_link_ctrl.sv
// rtl/frame_link_ctrl.sv - serial frame link test sequencer (mode stepping, lock wait, verdict)
// Optional lock-loss statistics: FRAME_CTRL_LOSS_STATS_EN.
module frame_link_ctrl
    import frame_pkg::*;
#(
    parameter int         FRAME_LEN       = FRAME_LEN_DEFAULT,
    parameter int         FRAMES_PER_MODE = 16,
    parameter int         LOCK_TIMEOUT    = 8,
    parameter logic [3:0] MODE_MASK       = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         sync_state,
    input  logic               out_enable,
    input  logic               data_wrong,
    output logic [MODE_W-1:0]  mode,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [FRAME_W-1:0] frame_count,
    output logic [LOSS_W-1:0]  loss_count
);

    localparam int         TIMEOUT_CLKS = LOCK_TIMEOUT * FRAME_LEN;
    localparam int         TW           = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int         PW           = $clog2(FRAMES_PER_MODE + 1);
    localparam logic [2:0] FIRST        = find_mode(MODE_MASK, 3'd0);
    localparam logic [PW-1:0] LAST_FRAME = PW'(FRAMES_PER_MODE - 1);

    ctrl_state_e        state_q, state_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [PW-1:0]      pmf_q, pmf_d;
    logic               timeout_q, timeout_d;
    logic               oe_q;
    logic               timer_load, timer_expired;
    logic               frame_edge;
    logic [2:0]         nxt;
    logic               loss_ok;

    assign frame_edge = out_enable && !oe_q;
    assign nxt        = find_mode(MODE_MASK, {1'b0, mode_q} + 3'd1);

    frame_timer #(.WIDTH(TW)) u_lock_timer (
        .clk        (clk),
        .rst        (reset),
        .load       (timer_load),
        .load_value (TW'(TIMEOUT_CLKS - 1)),
        .enable     (state_q == ST_WAIT_LOCK),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= FIRST[1:0];
            err_q     <= '0;
            frame_q   <= '0;
            pmf_q     <= '0;
            timeout_q <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            frame_q   <= frame_d;
            pmf_q     <= pmf_d;
            timeout_q <= timeout_d;
            oe_q      <= out_enable;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        err_d      = err_q;
        frame_d    = frame_q;
        pmf_d      = pmf_q;
        timeout_d  = timeout_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d     = '0;
                    frame_d   = '0;
                    pmf_d     = '0;
                    timeout_d = 1'b0;
                    mode_d    = FIRST[1:0];
                    if (FIRST[2]) begin
                        state_d    = ST_WAIT_LOCK;
                        timer_load = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT_LOCK: begin
                if (sync_state == SYNC_LOCKED) begin
                    state_d = ST_MEASURE;
                end else if (timer_expired) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (data_wrong && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                // Per-mode progress survives a relock; it is only cleared on mode advance or start.
                if (sync_state != SYNC_LOCKED) begin
                    state_d    = ST_WAIT_LOCK;
                    timer_load = 1'b1;
                end else if (frame_edge) begin
                    if (frame_q != '1) begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                    if (pmf_q == LAST_FRAME) begin
                        pmf_d = '0;
                        if (nxt[2]) begin
                            mode_d     = nxt[1:0];
                            state_d    = ST_WAIT_LOCK;
                            timer_load = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        pmf_d = pmf_q + PW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FRAME_CTRL_LOSS_STATS_EN
    logic [LOSS_W-1:0] loss_q;
    logic              loss_inc, loss_clr;

    assign loss_inc = (state_q == ST_MEASURE) && (sync_state != SYNC_LOCKED);
    assign loss_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_q <= '0;
        end else if (loss_clr) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    assign loss_count = loss_q;
    assign loss_ok    = (loss_q == '0);
`else
    assign loss_count = '0;
    assign loss_ok    = 1'b1;
`endif

    assign mode        = mode_q;
    assign busy        = (state_q == ST_WAIT_LOCK) || (state_q == ST_MEASURE);
    assign done        = (state_q == ST_DONE);
    assign pass        = done && (err_q == '0) && !timeout_q && loss_ok;
    assign err_count   = err_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_frame_link_ctrl.sv
// tb/tb_frame_link_ctrl.sv - randomized self-checking bench for frame_link_ctrl
module tb_frame_link_ctrl;
    import frame_pkg::*;

    localparam int FPM = 16;
`ifdef FRAME_CTRL_LOSS_STATS_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b, start_c;
    logic [1:0]  sync_state;
    logic        out_enable, data_wrong;
    logic [1:0]  mode_a, mode_b, mode_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [15:0] err_a, err_b, err_c, frame_a, frame_b, frame_c;
    logic [7:0]  loss_a, loss_b, loss_c;

    int checks = 0;
    int failures = 0;
    int sel = 0;

    logic [1:0]  o_mode;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_err, o_frame;
    logic [7:0]  o_loss;

    frame_link_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a), .sync_state(sync_state),
        .out_enable(out_enable), .data_wrong(data_wrong), .mode(mode_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a), .frame_count(frame_a), .loss_count(loss_a)
    );

    frame_link_ctrl #(.MODE_MASK(4'b0100)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .sync_state(sync_state),
        .out_enable(out_enable), .data_wrong(data_wrong), .mode(mode_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b), .frame_count(frame_b), .loss_count(loss_b)
    );

    frame_link_ctrl #(.MODE_MASK(4'b0000)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .sync_state(sync_state),
        .out_enable(out_enable), .data_wrong(data_wrong), .mode(mode_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .err_count(err_c), .frame_count(frame_c), .loss_count(loss_c)
    );

    always_comb begin
        if (sel == 1) begin
            o_mode = mode_b; o_busy = busy_b; o_done = done_b; o_pass = pass_b;
            o_err = err_b; o_frame = frame_b; o_loss = loss_b;
        end else begin
            o_mode = mode_a; o_busy = busy_a; o_done = done_a; o_pass = pass_a;
            o_err = err_a; o_frame = frame_a; o_loss = loss_a;
        end
    end

    task automatic pulse_start(input int which);
        if (which == 0) start_a = 1'b1;
        else if (which == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Link-side model: locks per mode, sends frames, injects errors/losses and tallies what should count.
    task automatic run_sequence(input int which, input logic [3:0] mask, input int err_mode,
                                input bit err_rand, input int loss_mode, input bit extra_start,
                                output int n_err, output int n_loss);
        bit loss_done = 1'b0;
        n_err = 0; n_loss = 0;
        sel = which;
        out_enable = 1'b0; data_wrong = 1'b0; sync_state = SYNC_SEARCH;
        pulse_start(which);
        for (int m = 0; m < 4; m++) begin
            if (mask[m]) begin
                if (sync_state != SYNC_LOCKED) begin
                    repeat ($urandom_range(1, 20)) begin
                        sync_state = ($urandom % 2) ? SYNC_VERIFY : SYNC_SEARCH;
                        @(negedge clk);
                    end
                    sync_state = SYNC_LOCKED;
                    repeat (2) @(negedge clk);
                end
                for (int f = 0; f < FPM; f++) begin
                    int hi = $urandom_range(1, 3);
                    int lo = $urandom_range(2, 5);
                    int nm = -1;
                    if (m == loss_mode && f == 5 && !loss_done) begin
                        loss_done = 1'b1;
                        sync_state = SYNC_HOLDOVER; out_enable = 1'b1;
                        @(negedge clk);
                        n_loss++;
                        data_wrong = 1'b1;
                        repeat (2) @(negedge clk);
                        data_wrong = 1'b0; out_enable = 1'b0;
                        repeat ($urandom_range(10, 40)) @(negedge clk);
                        sync_state = SYNC_LOCKED;
                        repeat (2) @(negedge clk);
                    end
                    if (extra_start && m == 1 && f == 8) pulse_start(which);
                    if (m == err_mode && f == 3) lo = 4;
                    checks++;
                    if (o_mode !== 2'(m)) begin
                        failures++;
                        $display("FAIL seq_mode m=%0d f=%0d got=%0d exp=%0d", m, f, o_mode, m);
                    end
                    out_enable = 1'b1;
                    @(negedge clk);
                    if (f == FPM - 1) begin
                        for (int k = m + 1; k < 4; k++) if (mask[k] && nm < 0) nm = k;
                        checks++;
                        if (nm >= 0 && o_mode !== 2'(nm)) begin
                            failures++;
                            $display("FAIL mode_advance got=%0d exp=%0d", o_mode, nm);
                        end else if (nm < 0 && o_done !== 1'b1) begin
                            failures++;
                            $display("FAIL done_after_last_frame got=%0b exp=1", o_done);
                        end
                        if ($urandom % 2) sync_state = SYNC_SEARCH;
                    end
                    repeat (hi - 1) @(negedge clk);
                    out_enable = 1'b0;
                    for (int i = 0; i < lo; i++) begin
                        data_wrong = 1'b0;
                        if (f < FPM - 1) begin
                            if (m == err_mode && f == 3 && i < 3) data_wrong = 1'b1;
                            else if (err_rand && ($urandom % 6) == 0) data_wrong = 1'b1;
                        end
                        if (data_wrong) n_err++;
                        @(negedge clk);
                    end
                    data_wrong = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start_a = 0; start_b = 0; start_c = 0;
        sync_state = SYNC_SEARCH; out_enable = 1'b1; data_wrong = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mode_a !== 2'd0) begin failures++; $display("FAIL rst_mode_a got=%0d exp=0", mode_a); end
        checks++; if (mode_b !== 2'd2) begin failures++; $display("FAIL rst_mode_b got=%0d exp=2", mode_b); end
        checks++; if (mode_c !== 2'd0) begin failures++; $display("FAIL rst_mode_c got=%0d exp=0", mode_c); end
        checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy_a, done_a, pass_a}); end
        checks++; if ({err_a, frame_a, loss_a} !== 40'd0) begin failures++; $display("FAIL rst_counts got=%h exp=0", {err_a, frame_a, loss_a}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        out_enable = 1'b0;
        checks++; if (busy_a !== 1'b0 || frame_a !== 16'd0) begin failures++; $display("FAIL idle_after_rst busy=%b frames=%0d exp 0/0", busy_a, frame_a); end
    endtask

    task automatic test_clean;
        int ne, nl;
        run_sequence(0, 4'hF, -1, 1'b0, -1, 1'b0, ne, nl);
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL clean_done done=%b busy=%b exp 1/0", done_a, busy_a); end
        checks++; if (frame_a !== 16'd64) begin failures++; $display("FAIL clean_frames got=%0d exp=64", frame_a); end
        checks++; if (err_a !== 16'd0 || loss_a !== 8'd0) begin failures++; $display("FAIL clean_err_loss got=%0d/%0d exp=0/0", err_a, loss_a); end
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL clean_pass got=%b exp=1", pass_a); end
        checks++; if (mode_a !== 2'd3) begin failures++; $display("FAIL clean_mode_hold got=%0d exp=3", mode_a); end
    endtask

    task automatic test_errors;
        int ne, nl;
        run_sequence(0, 4'hF, 1, 1'b0, -1, 1'b0, ne, nl);
        checks++; if (err_a !== 16'd3) begin failures++; $display("FAIL err3_count got=%0d exp=3", err_a); end
        checks++; if (pass_a !== 1'b0 || done_a !== 1'b1) begin failures++; $display("FAIL err3_verdict pass=%b done=%b exp 0/1", pass_a, done_a); end
        checks++; if (frame_a !== 16'd64) begin failures++; $display("FAIL err3_frames got=%0d exp=64", frame_a); end
    endtask

    task automatic test_random_errors;
        int ne, nl;
        run_sequence(0, 4'hF, -1, 1'b1, -1, 1'b0, ne, nl);
        checks++; if (err_a !== 16'(ne)) begin failures++; $display("FAIL rand_err_count got=%0d exp=%0d", err_a, ne); end
        checks++; if (pass_a !== (ne == 0)) begin failures++; $display("FAIL rand_err_pass got=%b exp=%b", pass_a, ne == 0); end
    endtask

    task automatic test_timeout;
        int n = 0;
        sel = 0;
        sync_state = SYNC_SEARCH; out_enable = 1'b0; data_wrong = 1'b0;
        pulse_start(0);
        while (n < 3000 && done_a !== 1'b1) begin
            case ($urandom_range(0, 2))
                0: sync_state = SYNC_SEARCH;
                1: sync_state = SYNC_VERIFY;
                default: sync_state = SYNC_HOLDOVER;
            endcase
            data_wrong = $urandom % 2;
            @(negedge clk);
            n++;
        end
        data_wrong = 1'b0;
        checks++; if (n !== 2048) begin failures++; $display("FAIL timeout_latency got=%0d exp=2048", n); end
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL timeout_pass got=%b exp=0", pass_a); end
        checks++; if (err_a !== 16'd0 || frame_a !== 16'd0) begin failures++; $display("FAIL timeout_counts err=%0d frames=%0d exp 0/0", err_a, frame_a); end
    endtask

    task automatic test_lock_loss;
        int ne, nl;
        run_sequence(0, 4'hF, -1, 1'b0, 2, 1'b0, ne, nl);
        checks++; if (frame_a !== 16'd64) begin failures++; $display("FAIL loss_frames got=%0d exp=64", frame_a); end
        checks++; if (loss_a !== (LOSS_EN ? 8'(nl) : 8'd0)) begin failures++; $display("FAIL loss_count got=%0d exp=%0d", loss_a, LOSS_EN ? nl : 0); end
        checks++; if (err_a !== 16'd0) begin failures++; $display("FAIL loss_err_ignored got=%0d exp=0", err_a); end
        checks++; if (pass_a !== !LOSS_EN) begin failures++; $display("FAIL loss_pass got=%b exp=%b", pass_a, !LOSS_EN); end
    endtask

    task automatic test_single_mode;
        int ne, nl;
        run_sequence(1, 4'b0100, -1, 1'b0, -1, 1'b0, ne, nl);
        checks++; if (frame_b !== 16'd16) begin failures++; $display("FAIL single_frames got=%0d exp=16", frame_b); end
        checks++; if (mode_b !== 2'd2 || pass_b !== 1'b1) begin failures++; $display("FAIL single_mode_pass mode=%0d pass=%b exp 2/1", mode_b, pass_b); end
        sel = 0;
    endtask

    task automatic test_empty_mask;
        pulse_start(2);
        checks++; if (done_c !== 1'b1 || busy_c !== 1'b0) begin failures++; $display("FAIL empty_done done=%b busy=%b exp 1/0", done_c, busy_c); end
        checks++; if (pass_c !== 1'b1 || mode_c !== 2'd0) begin failures++; $display("FAIL empty_pass pass=%b mode=%0d exp 1/0", pass_c, mode_c); end
    endtask

    task automatic test_back_to_back;
        int ne, nl;
        sel = 0;
        sync_state = SYNC_SEARCH;
        pulse_start(0);
        sync_state = SYNC_LOCKED;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            out_enable = 1'b1; @(negedge clk);
            out_enable = 1'b0; data_wrong = 1'b1; @(negedge clk);
            data_wrong = 1'b0; @(negedge clk);
        end
        checks++; if (frame_a !== 16'd20 || mode_a !== 2'd1) begin failures++; $display("FAIL mid_progress frames=%0d mode=%0d exp 20/1", frame_a, mode_a); end
        checks++; if (err_a !== 16'd19 || busy_a !== 1'b1) begin failures++; $display("FAIL mid_errs err=%0d busy=%b exp 19/1", err_a, busy_a); end
        reset = 1'b1;
        #1;
        checks++; if (mode_a !== 2'd0 || {busy_a, done_a, pass_a} !== 3'b000) begin failures++; $display("FAIL async_rst mode=%0d flags=%b exp 0/000", mode_a, {busy_a, done_a, pass_a}); end
        checks++; if ({err_a, frame_a, loss_a} !== 40'd0) begin failures++; $display("FAIL async_rst_counts got=%h exp=0", {err_a, frame_a, loss_a}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_sequence(0, 4'hF, -1, 1'b0, -1, 1'b1, ne, nl);
        checks++; if (frame_a !== 16'd64 || pass_a !== 1'b1) begin failures++; $display("FAIL restart_seq frames=%0d pass=%b exp 64/1", frame_a, pass_a); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_errors();
        test_random_errors();
        test_timeout();
        test_lock_loss();
        test_single_mode();
        test_empty_mask();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
